// File: rtl/frac_clk_gen.sv
// Multi-channel fractional clock generator: each channel toggles clk_out every int(+1) cycles of
// clk_48mhz, spreading the fraction with an accumulator. Define FRAC_CLK_SYNC_EN to add sync_start.
module frac_clk_gen #(
    parameter int NUM_CH   = 2,
    parameter int INT_W    = 8,
    parameter int FRAC_W   = 4,
    parameter int DEF_INT  = 31,
    parameter int DEF_FRAC = 4
) (
    input  logic                     clk_48mhz,
    input  logic                     reset_n,
    input  logic [NUM_CH-1:0]        enable,
    input  logic [NUM_CH-1:0]        cfg_load,
    input  logic [NUM_CH*INT_W-1:0]  div_int,
    input  logic [NUM_CH*FRAC_W-1:0] div_frac,
`ifdef FRAC_CLK_SYNC_EN
    input  logic                     sync_start,
`endif
    output logic [NUM_CH-1:0]        cfg_pending,
    output logic [NUM_CH-1:0]        clk_out,
    output logic [NUM_CH-1:0]        tick,
    output logic [2*NUM_CH-1:0]      dbg_state
);

    localparam int CNT_W = INT_W + 1;

    // IDLE: stopped, clk_out low. RUN: counting. DRAIN: enable dropped while high, finishing the half.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } ch_state_t;

    // cfg_load is a fire-and-forget strobe with no ready: it is always accepted, and
    // cfg_pending stays high until the captured values become the active interval.
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        ch_state_t               state_q, state_d;
        logic [CNT_W-1:0]        cnt_q, cnt_d;
        logic [FRAC_W-1:0]       acc_q, acc_d;
        logic [INT_W-1:0]        act_int_q, act_int_d, sh_int_q, sh_int_d;
        logic [FRAC_W-1:0]       act_frac_q, act_frac_d, sh_frac_q, sh_frac_d;
        logic                    pend_q, pend_d;
        logic                    clk_q, clk_d;
        logic                    tick_q, tick_d;
        logic [INT_W-1:0]        in_int;
        logic [FRAC_W-1:0]       in_frac;
        logic [FRAC_W:0]         acc_sum;
        logic [CNT_W-1:0]        eff_int;
        logic [CNT_W-1:0]        half_len;
        logic                    at_end;
        logic                    sync_hit;

        assign in_int  = div_int[ch*INT_W +: INT_W];
        assign in_frac = div_frac[ch*FRAC_W +: FRAC_W];

        // The carry of acc+frac lengthens the current half by one cycle.
        assign acc_sum  = {1'b0, acc_q} + {1'b0, act_frac_q};
        assign eff_int  = (act_int_q < INT_W'(2)) ? CNT_W'(2) : {1'b0, act_int_q};
        assign half_len = eff_int + CNT_W'(acc_sum[FRAC_W]);
        assign at_end   = (cnt_q == half_len - CNT_W'(1));

`ifdef FRAC_CLK_SYNC_EN
        assign sync_hit = sync_start & enable[ch];
`else
        assign sync_hit = 1'b0;
`endif

        always_ff @(posedge clk_48mhz) begin
            if (!reset_n) begin
                state_q    <= ST_IDLE;
                cnt_q      <= '0;
                acc_q      <= '0;
                act_int_q  <= INT_W'(DEF_INT);
                act_frac_q <= FRAC_W'(DEF_FRAC);
                sh_int_q   <= INT_W'(DEF_INT);
                sh_frac_q  <= FRAC_W'(DEF_FRAC);
                pend_q     <= 1'b0;
                clk_q      <= 1'b0;
                tick_q     <= 1'b0;
            end else begin
                state_q    <= state_d;
                cnt_q      <= cnt_d;
                acc_q      <= acc_d;
                act_int_q  <= act_int_d;
                act_frac_q <= act_frac_d;
                sh_int_q   <= sh_int_d;
                sh_frac_q  <= sh_frac_d;
                pend_q     <= pend_d;
                clk_q      <= clk_d;
                tick_q     <= tick_d;
            end
        end

        always_comb begin
            state_d    = state_q;
            cnt_d      = cnt_q;
            acc_d      = acc_q;
            act_int_d  = act_int_q;
            act_frac_d = act_frac_q;
            sh_int_d   = sh_int_q;
            sh_frac_d  = sh_frac_q;
            pend_d     = pend_q;
            clk_d      = clk_q;
            tick_d     = 1'b0;

            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    acc_d = '0;
                    clk_d = 1'b0;
                    if (pend_q) begin
                        act_int_d  = sh_int_q;
                        act_frac_d = sh_frac_q;
                        pend_d     = 1'b0;
                    end
                    if (enable[ch]) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    if (state_q == ST_RUN && !enable[ch] && !clk_q) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        acc_d   = '0;
                    end else if (at_end) begin
                        cnt_d = '0;
                        clk_d = !clk_q;
                        acc_d = acc_sum[FRAC_W-1:0];
                        if (!clk_q) begin
                            tick_d = 1'b1;
                        end else begin
                            // Falling edge closes a full period: the only glitch-free point to switch.
                            if (pend_q) begin
                                act_int_d  = sh_int_q;
                                act_frac_d = sh_frac_q;
                                acc_d      = '0;
                                pend_d     = 1'b0;
                            end
                            if (state_q == ST_DRAIN || !enable[ch]) begin
                                state_d = ST_IDLE;
                                acc_d   = '0;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (state_q == ST_RUN && !enable[ch]) begin
                            state_d = ST_DRAIN;
                        end
                    end
                end
            endcase

            if (cfg_load[ch]) begin
                sh_int_d  = in_int;
                sh_frac_d = in_frac;
                pend_d    = 1'b1;
            end

            if (sync_hit) begin
                state_d = ST_RUN;
                cnt_d   = '0;
                acc_d   = '0;
                clk_d   = 1'b0;
                tick_d  = 1'b0;
                pend_d  = 1'b0;
                if (cfg_load[ch]) begin
                    act_int_d  = in_int;
                    act_frac_d = in_frac;
                end else if (pend_q) begin
                    act_int_d  = sh_int_q;
                    act_frac_d = sh_frac_q;
                end
            end
        end

        assign clk_out[ch]           = clk_q;
        assign tick[ch]              = tick_q;
        assign cfg_pending[ch]       = pend_q;
        assign dbg_state[2*ch +: 2]  = state_q;
    end

endmodule

// File: tb/tb_frac_clk_gen.sv
// Bench for frac_clk_gen: a time-based reference model predicts clk_out/tick/cfg_pending each
// cycle into a queue that a separate monitor pops and compares; plus directed timing checks.
module tb_frac_clk_gen;

    localparam int NUM_CH = 2;
    localparam int INT_W  = 8;
    localparam int FRAC_W = 4;
    localparam int W      = 3 * NUM_CH;

    logic                     clk_48mhz = 1'b0;
    logic                     reset_n;
    logic [NUM_CH-1:0]        enable;
    logic [NUM_CH-1:0]        cfg_load;
    logic [NUM_CH*INT_W-1:0]  div_int;
    logic [NUM_CH*FRAC_W-1:0] div_frac;
`ifdef FRAC_CLK_SYNC_EN
    logic                     sync_start;
`endif
    logic [NUM_CH-1:0]        cfg_pending;
    logic [NUM_CH-1:0]        clk_out;
    logic [NUM_CH-1:0]        tick;
    logic [2*NUM_CH-1:0]      dbg_state;

    frac_clk_gen #(
        .NUM_CH(NUM_CH), .INT_W(INT_W), .FRAC_W(FRAC_W), .DEF_INT(31), .DEF_FRAC(4)
    ) dut (
        .clk_48mhz  (clk_48mhz),
        .reset_n    (reset_n),
        .enable     (enable),
        .cfg_load   (cfg_load),
        .div_int    (div_int),
        .div_frac   (div_frac),
`ifdef FRAC_CLK_SYNC_EN
        .sync_start (sync_start),
`endif
        .cfg_pending(cfg_pending),
        .clk_out    (clk_out),
        .tick       (tick),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    always #10 clk_48mhz = ~clk_48mhz;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [W-1:0] exp_q[$];
    int           exp_cyc_q[$];
    int           tick_log0[$];

    // ---------------- reference model ----------------
    // Half-period k after an origin ends at origin + floor((k+1) * interval), interval in 1/16ths.
    bit m_run[NUM_CH];
    bit m_drain[NUM_CH];
    bit m_clk[NUM_CH];
    bit m_pend[NUM_CH];
    int m_ai[NUM_CH], m_af[NUM_CH], m_si[NUM_CH], m_sf[NUM_CH];
    int m_t0[NUM_CH], m_n[NUM_CH];

    always @(posedge clk_48mhz) begin : model
        logic [W-1:0] ev;
        int x;
        bit tk;
        cyc++;
        ev = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            tk = 1'b0;
            if (!reset_n) begin
                m_run[c] = 0; m_drain[c] = 0; m_clk[c] = 0; m_pend[c] = 0;
                m_ai[c] = 31; m_af[c] = 4; m_si[c] = 31; m_sf[c] = 4;
                m_t0[c] = 0; m_n[c] = 0;
            end else begin
                x = ((m_ai[c] < 2) ? 2 : m_ai[c]) * 16 + m_af[c];
                if (!m_run[c]) begin
                    if (m_pend[c]) begin
                        m_ai[c] = m_si[c]; m_af[c] = m_sf[c]; m_pend[c] = 0;
                    end
                    if (enable[c]) begin
                        m_run[c] = 1; m_drain[c] = 0; m_t0[c] = cyc; m_n[c] = 0;
                    end
                end else if (!m_drain[c] && !enable[c] && !m_clk[c]) begin
                    m_run[c] = 0;
                end else if (cyc == m_t0[c] + ((m_n[c] + 1) * x) / 16) begin
                    m_n[c]++;
                    if (!m_clk[c]) begin
                        m_clk[c] = 1; tk = 1'b1;
                    end else begin
                        m_clk[c] = 0;
                        if (m_pend[c]) begin
                            m_ai[c] = m_si[c]; m_af[c] = m_sf[c]; m_pend[c] = 0;
                            m_t0[c] = cyc; m_n[c] = 0;
                        end
                        if (m_drain[c] || !enable[c]) begin
                            m_run[c] = 0; m_drain[c] = 0;
                        end
                    end
                end else if (!enable[c]) begin
                    m_drain[c] = 1;
                end
                if (cfg_load[c]) begin
                    m_si[c] = int'(div_int[c*INT_W +: INT_W]);
                    m_sf[c] = int'(div_frac[c*FRAC_W +: FRAC_W]);
                    m_pend[c] = 1;
                end
`ifdef FRAC_CLK_SYNC_EN
                if (sync_start && enable[c]) begin
                    m_run[c] = 1; m_drain[c] = 0; m_clk[c] = 0; tk = 1'b0;
                    m_t0[c] = cyc; m_n[c] = 0;
                    // A same-cycle load already sits in the shadow, so the shadow holds the winner.
                    m_ai[c] = m_pend[c] ? m_si[c] : m_ai[c];
                    m_af[c] = m_pend[c] ? m_sf[c] : m_af[c];
                    m_pend[c] = 0;
                end
`endif
            end
            ev[c]            = m_clk[c];
            ev[NUM_CH + c]   = tk;
            ev[2*NUM_CH + c] = m_pend[c];
        end
        exp_q.push_back(ev);
        exp_cyc_q.push_back(cyc);
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk_48mhz) begin : monitor
        logic [W-1:0] got, want;
        int wc;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            wc   = exp_cyc_q.pop_front();
            got  = {cfg_pending, tick, clk_out};
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL outputs cyc=%0d {pend,tick,clk} got=%b exp=%b", wc, got, want);
            end
        end
        if (tick[0] === 1'b1) tick_log0.push_back(cyc);
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk_48mhz);
    endtask

    task automatic load(input int c, input int vi, input int vf);
        div_int[c*INT_W +: INT_W]    = INT_W'(vi);
        div_frac[c*FRAC_W +: FRAC_W] = FRAC_W'(vf);
        cfg_load[c] = 1'b1;
        step(1);
        cfg_load[c] = 1'b0;
    endtask

    task automatic wait_level(input int c, input logic lvl);
        int k;
        k = 0;
        while (clk_out[c] !== lvl && k < 400) begin
            step(1);
            k++;
        end
        n_vec++;
        if (k >= 400) begin
            n_err++;
            $display("FAIL wait_level ch%0d got=timeout exp=%b", c, lvl);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        int e0;
        int off[4];
        off = '{31, 93, 156, 218};
        reset_n = 1'b0; enable = '0; cfg_load = '0; div_int = '0; div_frac = '0;
`ifdef FRAC_CLK_SYNC_EN
        sync_start = 1'b0;
`endif
        step(3);
        reset_n = 1'b1;
        step(2);
        n_vec++;
        if (dbg_state !== '0) begin
            n_err++;
            $display("FAIL reset_state got=%b exp=%b", dbg_state, {2*NUM_CH{1'b0}});
        end

        // Default 31.25: rises at 31, 93, 156, 218 cycles after the enable edge.
        tick_log0.delete();
        enable[0] = 1'b1;
        e0 = cyc + 1;
        step(260);
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (tick_log0.size() <= i) begin
                n_err++;
                $display("FAIL default_rise%0d got=none exp=%0d", i, e0 + off[i]);
            end else if (tick_log0[i] != e0 + off[i]) begin
                n_err++;
                $display("FAIL default_rise%0d got=%0d exp=%0d", i, tick_log0[i], e0 + off[i]);
            end
        end

        // ch1: default, then 6 MHz, then clamped int=1
        enable[1] = 1'b1;
        step(45);
        load(1, 4, 0);
        step(150);
        load(1, 1, 0);
        step(60);

        // Drop ch0 enable 10 cycles into a high half, then re-enable
        wait_level(0, 1'b0);
        wait_level(0, 1'b1);
        step(9);
        enable[0] = 1'b0;
        step(60);
        enable[0] = 1'b1;
        step(80);

        // Back-to-back loads before the apply point: last wins
        load(0, 8, 0);
        step(3);
        load(0, 12, 0);
        step(200);

        // Config on a disabled channel applies the next cycle
        enable[1] = 1'b0;
        step(20);
        load(1, 5, 3);
        step(5);
        enable[1] = 1'b1;
        step(100);

`ifdef FRAC_CLK_SYNC_EN
        load(0, 6, 0);
        load(1, 6, 0);
        step(40);
        sync_start = 1'b1;
        step(1);
        sync_start = 1'b0;
        step(100);
        div_int[0 +: INT_W] = INT_W'(9);
        div_frac[0 +: FRAC_W] = FRAC_W'(2);
        cfg_load[0] = 1'b1;
        sync_start = 1'b1;
        step(1);
        cfg_load[0] = 1'b0;
        sync_start = 1'b0;
        step(100);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 99) < 2) enable[c] = ~enable[c];
                if ($urandom_range(0, 99) < 3) begin
                    div_int[c*INT_W +: INT_W]    = INT_W'($urandom_range(0, 20));
                    div_frac[c*FRAC_W +: FRAC_W] = FRAC_W'($urandom_range(0, 15));
                    cfg_load[c] = 1'b1;
                end else begin
                    cfg_load[c] = 1'b0;
                end
            end
`ifdef FRAC_CLK_SYNC_EN
            sync_start = ($urandom_range(0, 199) == 0);
`endif
            step(1);
        end
        cfg_load = '0;
`ifdef FRAC_CLK_SYNC_EN
        sync_start = 1'b0;
`endif

        // Reset mid-period with a config pending
        enable = '1;
        step(37);
        load(0, 6, 1);
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        step(150);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
